// File: rtl/upscaler_pkg.sv
// Shared constants for the upscaler datapath: pixel/product widths and the
// default fixed-point scale of the interpolation weights.
package upscaler_pkg;

  localparam int PIXEL_W          = 8;
  localparam int PRODUCT_W        = 20;
  localparam int PIXEL_MAX        = 255;
  localparam int WEIGHT_FRAC_BITS = 7;

endpackage : upscaler_pkg

// File: rtl/round_clamp_pixel.sv
// Rounds an accumulated pixel*weight sum back to pixel scale (half toward
// +inf) and clamps it to an unsigned pixel, flagging any clamp.
module round_clamp_pixel
  import upscaler_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = WEIGHT_FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]   sum,
  output logic        [PIXEL_W-1:0] pixel,
  output logic                      sat
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam logic signed [ACC_W:0] HALF_LSB = (ACC_W+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_W:0] MAX_VAL  = (ACC_W+1)'(PIXEL_MAX);

  logic signed [ACC_W:0] rounded_s;
  logic signed [ACC_W:0] scaled_s;

  // Round and rescale.
  always_comb begin
    rounded_s = {sum[ACC_W-1], sum} + HALF_LSB;
    scaled_s  = rounded_s >>> FRAC_BITS;
  end

  // Clamp into pixel range.
  always_comb begin
    pixel = {PIXEL_W{1'b0}};
    sat   = 1'b0;
    if (scaled_s[ACC_W]) begin
      pixel = {PIXEL_W{1'b0}};
      sat   = 1'b1;
    end else if (scaled_s > MAX_VAL) begin
      pixel = PIXEL_W'(PIXEL_MAX);
      sat   = 1'b1;
    end else begin
      pixel = scaled_s[PIXEL_W-1:0];
      sat   = 1'b0;
    end
  end

endmodule : round_clamp_pixel

// File: rtl/tap_accum_clamp.sv
// Accumulates NUM_TAPS signed products per output pixel, then rounds, rescales
// and clamps the sum into a registered pixel behind a valid/ready handshake.
module tap_accum_clamp
  import upscaler_pkg::*;
#(
  parameter int NUM_TAPS  = 4,
  parameter int FRAC_BITS = WEIGHT_FRAC_BITS,
  parameter int ACC_W     = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [PRODUCT_W-1:0] in_product,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [PIXEL_W-1:0]   out_pixel,
  output logic                        out_sat
);

  localparam int                CNT_W    = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0]  LAST_TAP = CNT_W'(NUM_TAPS - 1);

  logic [CNT_W-1:0]        tap_cnt_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    out_valid_r;
  logic [PIXEL_W-1:0]      out_pixel_r;
  logic                    out_sat_r;

  logic                    last_tap_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic signed [ACC_W-1:0] product_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic [PIXEL_W-1:0]      pixel_s;
  logic                    sat_s;

  // Handshake qualification and running sum; only the last tap stalls on a held result.
  always_comb begin
    last_tap_s    = (tap_cnt_r == LAST_TAP);
    in_ready_s    = !flush && !(last_tap_s && out_valid_r && !out_ready);
    accept_s      = in_valid && in_ready_s;
    product_ext_s = ACC_W'(in_product);
    if (tap_cnt_r == {CNT_W{1'b0}}) begin
      sum_s = product_ext_s;
    end else begin
      sum_s = acc_r + product_ext_s;
    end
  end

  round_clamp_pixel #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_clamp (
    .sum   (sum_s),
    .pixel (pixel_s),
    .sat   (sat_s)
  );

  // Tap counter and accumulator; flush drops the partial group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt_r <= {CNT_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
    end else if (flush) begin
      tap_cnt_r <= {CNT_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      acc_r <= sum_s;
      if (last_tap_s) begin
        tap_cnt_r <= {CNT_W{1'b0}};
      end else begin
        tap_cnt_r <= tap_cnt_r + CNT_W'(1);
      end
    end else begin
      tap_cnt_r <= tap_cnt_r;
      acc_r     <= acc_r;
    end
  end

  // Output register: a new result may replace one being consumed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_pixel_r <= {PIXEL_W{1'b0}};
      out_sat_r   <= 1'b0;
    end else if (accept_s && last_tap_s) begin
      out_valid_r <= 1'b1;
      out_pixel_r <= pixel_s;
      out_sat_r   <= sat_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_pixel = out_pixel_r;
  assign out_sat   = out_sat_r;

endmodule : tap_accum_clamp

// File: tb/tb_tap_accum_clamp.sv
// Scoreboard bench for tap_accum_clamp: a reference model predicts each pixel
// when its last tap is accepted; the output monitor pops and compares.
module tb_tap_accum_clamp;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] in_product;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_pixel;
  logic               out_sat;

  typedef struct packed {
    logic [7:0] pix;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt;
  int   err_cnt;
  int   m_cnt;
  int   m_acc;

  tap_accum_clamp #(.NUM_TAPS(4), .FRAC_BITS(7), .ACC_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_sat    (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    check_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model of the accumulate/round/clamp path.
  task automatic model_accept(input int p);
    int s;
    int r;
    exp_t e;
    s = (m_cnt == 0) ? p : m_acc + p;
    if (m_cnt == 3) begin
      r = (s + 64) >>> 7;
      if (r < 0) begin
        e.pix = 8'd0;   e.sat = 1'b1;
      end else if (r > 255) begin
        e.pix = 8'd255; e.sat = 1'b1;
      end else begin
        e.pix = 8'(r);  e.sat = 1'b0;
      end
      exp_q.push_back(e);
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    m_acc = s;
  endtask

  task automatic send_tap(input int p, output int waits);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    in_valid   = 1'b1;
    in_product = 20'(p);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (ok) begin
      model_accept(p);
    end else begin
      check_val("tap_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waits    = n;
  endtask

  task automatic send_group(input int a, input int b, input int c, input int d, output int waits);
    int w;
    int tot;
    tot = 0;
    send_tap(a, w); tot += w;
    send_tap(b, w); tot += w;
    send_tap(c, w); tot += w;
    send_tap(d, w); tot += w;
    waits = tot;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("out_pixel", int'(out_pixel), int'(e.pix));
        check_val("out_sat", int'(out_sat), int'(e.sat));
      end
    end
  end

  initial begin
    int w;
    int held;
    check_cnt  = 0;
    err_cnt    = 0;
    m_cnt      = 0;
    m_acc      = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_product = 20'sd0;
    out_ready  = 1'b1;

    // Reset state
    #12;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_pixel", int'(out_pixel), 0);
    check_val("rst_out_sat", int'(out_sat), 0);
    check_val("rst_in_ready", int'(in_ready), 1);
    flush = 1'b1;
    #1;
    check_val("rst_in_ready_flush", int'(in_ready), 0);
    flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity, with latency and no-bubble throughput
    send_tap(25600, w); send_tap(0, w); send_tap(0, w);
    check_val("latency_before", int'(out_valid), 0);
    send_tap(0, w);
    check_val("latency_after", int'(out_valid), 1);
    drain();
    send_group(-1280, 12800, 12800, -1280, w);
    check_val("throughput_waits", w, 0);
    // Rounding and clamping
    send_group(64, 0, 0, 0, w);
    send_group(63, 0, 0, 0, w);
    send_group(-64, 0, 0, 0, w);
    send_group(-65, 0, 0, 0, w);
    send_group(-30000, 0, 0, 0, w);
    send_group(32640, 32640, 0, 0, w);
    send_group(-524288, -524288, -524288, -524288, w);
    send_group(524287, 524287, 524287, 524287, w);
    drain();

    // Backpressure: first result held, taps 5-7 still flow, tap 8 stalls
    out_ready = 1'b0;
    send_group(12800, 0, 0, 0, w);
    check_val("bp_first_valid", int'(out_valid), 1);
    held = int'(out_pixel);
    send_tap(25600, w); check_val("bp_tap5_wait", w, 0);
    send_tap(0, w);     check_val("bp_tap6_wait", w, 0);
    send_tap(0, w);     check_val("bp_tap7_wait", w, 0);
    in_valid   = 1'b1;
    in_product = 20'sd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_tap8_stall", int'(in_ready), 0);
      check_val("bp_hold_pixel", int'(out_pixel), held);
    end
    check_val("bp_held_value", held, 100);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_tap(0, w);
    check_val("bp_tap8_wait", w, 0);
    check_val("bp_second_valid", int'(out_valid), 1);
    check_val("bp_second_pixel", int'(out_pixel), 200);
    drain();

    // Flush mid-group; a tap presented with flush is dropped
    send_tap(5000, w); send_tap(7000, w);
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_product = 20'sd9999;
    @(negedge clk);
    check_val("flush_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    m_cnt    = 0;
    m_acc    = 0;
    send_group(12800, 0, 0, 0, w);
    drain();

    // Reset mid-group
    send_tap(5000, w); send_tap(7000, w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cnt = 0;
    m_acc = 0;
    send_group(12800, 0, 0, 0, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule : tb_tap_accum_clamp
